// File: rtl/npu_inst_pkg.sv
// Shared types and constants for the NPU instruction queue: FSM states,
// control-word opcodes and the mask that identifies control words.
package npu_inst_pkg;

  localparam int INST_W_DEF = 128;

  localparam logic [3:0] CMD_CLEAR = 4'd1;
  localparam logic [3:0] CMD_START = 4'd2;

  // A word whose bits above the low nibble are all zero is a control word.
  localparam logic [INST_W_DEF-1:0] CTRL_MASK = {{(INST_W_DEF-4){1'b1}}, 4'b0000};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } npu_state_e;

endpackage

// File: rtl/npu_inst_ram.sv
// Program RAM: one write port, one registered read port, inferable as block RAM.
// The read register only updates on rd_en, so its output holds between reads.
module npu_inst_ram
  import npu_inst_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/npu_inst_queue.sv
// Instruction buffer/sequencer: loads instruction words into program RAM and
// replays them to the executor on START. Define NPU_INST_QUEUE_TIMEOUT_EN to
// let WAIT_ACK give up after ACK_TIMEOUT cycles of exec_ready staying high.
module npu_inst_queue
  import npu_inst_pkg::*;
#(
  parameter int INST_W      = INST_W_DEF,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] npu_inst,
  input  logic              npu_inst_en,
  output logic [INST_W-1:0] exec_inst,
  output logic              exec_inst_en,
  input  logic              exec_ready,
  output logic              npu_inst_ready,
  output logic [ADDR_W:0]   inst_count,
  output logic              overflow,
  output logic              drop_err
);

  // Handshake: exec_inst_en is a one-cycle issue strobe with exec_inst valid
  // in that cycle; the executor acknowledges by dropping exec_ready (busy) and
  // completes by raising it again. npu_inst_en is a one-cycle input strobe.

  npu_state_e        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   rd_ptr;

  logic is_ctrl, clear_cmd, start_cmd, inst_wr_req, full, wr_en, rd_en;

  assign is_ctrl     = ((npu_inst & CTRL_MASK) == '0);
  assign clear_cmd   = npu_inst_en && is_ctrl && (npu_inst[3:0] == CMD_CLEAR);
  assign start_cmd   = npu_inst_en && is_ctrl && (npu_inst[3:0] == CMD_START);
  assign inst_wr_req = npu_inst_en && !is_ctrl;
  assign full        = (inst_count == (ADDR_W+1)'(DEPTH));
  assign wr_en       = inst_wr_req && (state == S_IDLE) && !full;
  // A CLEAR landing in FETCH must not disturb the held exec_inst value.
  assign rd_en       = (state == S_FETCH) && !clear_cmd;

  npu_inst_ram #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (npu_inst),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (exec_inst)
  );

`ifdef NPU_INST_QUEUE_TIMEOUT_EN
  localparam int ACK_CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [ACK_CNT_W-1:0] ack_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      inst_count     <= '0;
      overflow       <= 1'b0;
      drop_err       <= 1'b0;
      exec_inst_en   <= 1'b0;
      npu_inst_ready <= 1'b1;
`ifdef NPU_INST_QUEUE_TIMEOUT_EN
      ack_cnt        <= '0;
`endif
    end else begin
      exec_inst_en <= 1'b0;
      if (clear_cmd) begin
        state          <= S_IDLE;
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        inst_count     <= '0;
        overflow       <= 1'b0;
        drop_err       <= 1'b0;
        npu_inst_ready <= 1'b1;
      end else begin
        if (inst_wr_req) begin
          if (state != S_IDLE) begin
            drop_err <= 1'b1;
          end else if (full) begin
            overflow <= 1'b1;
          end else begin
            wr_ptr     <= wr_ptr + ADDR_W'(1);
            inst_count <= inst_count + (ADDR_W+1)'(1);
          end
        end

        case (state)
          S_IDLE: begin
            if (start_cmd && (inst_count != '0)) begin
              rd_ptr         <= '0;
              state          <= S_FETCH;
              npu_inst_ready <= 1'b0;
            end
          end
          S_FETCH: begin
            state        <= S_ISSUE;
            exec_inst_en <= 1'b1;
          end
          S_ISSUE: begin
            rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            state  <= S_WAIT_ACK;
`ifdef NPU_INST_QUEUE_TIMEOUT_EN
            ack_cnt <= '0;
`endif
          end
          S_WAIT_ACK: begin
            if (!exec_ready) begin
              state <= S_WAIT_DONE;
`ifdef NPU_INST_QUEUE_TIMEOUT_EN
            end else if (ack_cnt == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
              // Executor never went busy: treat as a single-cycle instruction.
              if (rd_ptr == inst_count) begin
                state          <= S_IDLE;
                npu_inst_ready <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end else begin
              ack_cnt <= ack_cnt + ACK_CNT_W'(1);
`endif
            end
          end
          S_WAIT_DONE: begin
            if (exec_ready) begin
              if (rd_ptr == inst_count) begin
                state          <= S_IDLE;
                npu_inst_ready <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_inst_queue.sv
// Randomized bench for npu_inst_queue: a queue-based program model, a simple
// executor model and a pulse monitor; ack-timeout expectations follow the macro.
module tb_npu_inst_queue;

  localparam int INST_W      = 128;
  localparam int DEPTH       = 1024;
  localparam int ADDR_W      = 10;
  localparam int ACK_TIMEOUT = 16;

  localparam logic [127:0] W_CLEAR = 128'd1;
  localparam logic [127:0] W_START = 128'd2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [INST_W-1:0] npu_inst = '0;
  logic              npu_inst_en = 1'b0;
  logic [INST_W-1:0] exec_inst;
  logic              exec_inst_en;
  logic              exec_ready = 1'b1;
  logic              npu_inst_ready;
  logic [ADDR_W:0]   inst_count;
  logic              overflow;
  logic              drop_err;

  npu_inst_queue #(
    .INST_W      (INST_W),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .npu_inst       (npu_inst),
    .npu_inst_en    (npu_inst_en),
    .exec_inst      (exec_inst),
    .exec_inst_en   (exec_inst_en),
    .exec_ready     (exec_ready),
    .npu_inst_ready (npu_inst_ready),
    .inst_count     (inst_count),
    .overflow       (overflow),
    .drop_err       (drop_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [127:0] m_prog[$];
  logic [127:0] exp_q[$];
  bit           m_ovf = 0;
  bit           m_drop = 0;
  bit           m_running = 0;

  int total = 0;
  int bad = 0;

  // ---------------- monitor + executor model ----------------
  int           pulse_cyc_q[$];
  logic [127:0] pulse_dat_q[$];
  int           rise_q[$];
  int           rdy_rise_q[$];
  logic         prev_rdy = 1'b1;
  int           ex_mode = 0;   // 0: busy 5 cycles per issue, 1: never busy
  bit           arm = 0;
  int           hold = 0;

  always @(negedge clk) begin
    if (exec_inst_en) begin
      pulse_cyc_q.push_back(cyc);
      pulse_dat_q.push_back(exec_inst);
    end
    if (npu_inst_ready && !prev_rdy) rdy_rise_q.push_back(cyc);
    prev_rdy = npu_inst_ready;
    if (ex_mode == 0) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          exec_ready = 1'b1;
          rise_q.push_back(cyc);
        end
      end else if (arm) begin
        exec_ready = 1'b0;
        hold = 5;
        arm = 0;
      end
      if (exec_inst_en) arm = 1;
    end else begin
      exec_ready = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_inst();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[127 - $urandom_range(0, 3)] = 1'b1;
    return r;
  endfunction

  // One-cycle strobe; also applies the word to the model.
  task automatic send(input logic [127:0] w);
    if (w[127:4] == '0) begin
      if (w[3:0] == 4'd1) begin
        m_prog.delete();
        m_ovf = 0;
        m_drop = 0;
      end
    end else if (m_running) begin
      m_drop = 1;
    end else if (m_prog.size() < DEPTH) begin
      m_prog.push_back(w);
    end else begin
      m_ovf = 1;
    end
    npu_inst = w;
    npu_inst_en = 1'b1;
    tick();
    npu_inst_en = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_count"}, inst_count, m_prog.size());
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_drop"}, drop_err, m_drop);
  endtask

  task automatic clear_mon();
    pulse_cyc_q.delete();
    pulse_dat_q.delete();
    rise_q.delete();
    rdy_rise_q.delete();
  endtask

  task automatic run(input string tag, input int budget, input bit inject,
                     input logic [127:0] iw, output int t0);
    bit done_inj;
    done_inj = 0;
    clear_mon();
    t0 = cyc;
    m_running = 1;
    send(W_START);
    for (int i = 0; i < budget; i++) begin
      if (npu_inst_ready) break;
      if (inject && !done_inj && pulse_cyc_q.size() >= 1) begin
        send(iw);
        done_inj = 1;
      end else begin
        tick();
      end
    end
    m_running = 0;
    check({tag, "_finished"}, npu_inst_ready, 1'b1);
  endtask

  task automatic verify_run(input string tag, input int t0);
    int n;
    int exp_c;
    int last;
    exp_q = m_prog;
    n = exp_q.size();
    check({tag, "_npulse"}, pulse_dat_q.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [127:0] e;
      e = exp_q.pop_front();
      check({tag, "_data"}, (i < pulse_dat_q.size()) ? pulse_dat_q[i] : 'x, e);
      if (i == 0) exp_c = t0 + 2;
      else if (ex_mode == 1) exp_c = t0 + 2 + i * (ACK_TIMEOUT + 2);
      else exp_c = (i - 1 < rise_q.size()) ? rise_q[i-1] + 2 : -1;
      check({tag, "_pulse_cyc"}, (i < pulse_cyc_q.size()) ? pulse_cyc_q[i] : -1, exp_c);
    end
    if (ex_mode == 1) last = t0 + 2 + (n - 1) * (ACK_TIMEOUT + 2) + ACK_TIMEOUT + 1;
    else last = (rise_q.size() > 0) ? rise_q[rise_q.size()-1] + 1 : -1;
    check({tag, "_ready_cyc"}, (rdy_rise_q.size() > 0) ? rdy_rise_q[rdy_rise_q.size()-1] : -1, last);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    logic [127:0] saved[$];

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();

    check("reset_ready", npu_inst_ready, 1'b1);
    check("reset_en", exec_inst_en, 1'b0);
    check("reset_inst", exec_inst, '0);
    check_regs("reset");

    // START with an empty program does nothing.
    clear_mon();
    send(W_START);
    repeat (20) tick();
    check("empty_npulse", pulse_cyc_q.size(), 0);
    check("empty_ready", npu_inst_ready, 1'b1);
    check_regs("empty");

    // Load three instructions; unknown control values are ignored.
    repeat (3) send(rand_inst());
    send(128'h7);
    send(128'h0);
    tick();
    check_regs("load");

    run("basic", 200, 0, '0, t0);
    verify_run("basic", t0);

    // Replay without reloading, with a write dropped mid-run.
    run("replay", 200, 1, rand_inst(), t0);
    verify_run("replay", t0);
    check_regs("replay");

    // Fill past capacity, replay the full program, then clear.
    send(W_CLEAR);
    tick();
    check_regs("clear1");
    repeat (DEPTH + 1) send(rand_inst());
    tick();
    check_regs("full");
    run("full_run", 12000, 0, '0, t0);
    verify_run("full_run", t0);
    send(W_CLEAR);
    tick();
    check_regs("clear2");

    // Abort with CLEAR while waiting for the second instruction to finish.
    repeat (3) send(rand_inst());
    saved = m_prog;
    clear_mon();
    send(W_START);
    for (int i = 0; i < 100; i++) begin
      if (pulse_cyc_q.size() >= 2) break;
      tick();
    end
    check("abort_two_issued", pulse_cyc_q.size(), 2);
    repeat (2) tick();
    send(W_CLEAR);
    check("abort_ready", npu_inst_ready, 1'b1);
    repeat (20) tick();
    check("abort_npulse", pulse_cyc_q.size(), 2);
    for (int i = 0; i < 2; i++)
      check("abort_data", (i < pulse_dat_q.size()) ? pulse_dat_q[i] : 'x, saved[i]);
    check_regs("abort");

    // Executor that never goes busy.
    ex_mode = 1;
    tick();
    repeat (3) send(rand_inst());
    tick();
`ifdef NPU_INST_QUEUE_TIMEOUT_EN
    run("timeout", 400, 0, '0, t0);
    verify_run("timeout", t0);
`else
    clear_mon();
    send(W_START);
    repeat (60) tick();
    check("stuck_npulse", pulse_cyc_q.size(), 1);
    check("stuck_ready", npu_inst_ready, 1'b0);
    send(W_CLEAR);
    check("stuck_clear_ready", npu_inst_ready, 1'b1);
`endif
    check_regs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npu_inst_queue.md
# npu_inst_queue

Instruction buffer and sequencer between the instruction-join stage and the NPU instruction executor. It captures 128-bit instruction words as the join stage emits them and stores them in an on-chip program RAM. On a START control word it replays the program to the executor one instruction at a time, handshaking on the executor's ready line. It also reports when the whole program has completed.

## Interface
- `INST_W`, 128: instruction width.
- `DEPTH`, 1024: program RAM depth, in instructions.
- `ADDR_W`, 10: log2(DEPTH).
- `ACK_TIMEOUT`, 16: cycles to wait for the executor to go busy; used only with the macro.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `npu_inst`  in  INST_W: word from the join stage.
- `npu_inst_en`  in  1: one-cycle strobe qualifying `npu_inst`.
- `exec_inst`  out  INST_W: instruction presented to the executor.
- `exec_inst_en`  out  1: one-cycle issue strobe.
- `exec_ready`  in  1: executor idle (high) or busy (low).
- `npu_inst_ready`  out  1: queue idle, or program finished.
- `inst_count`  out  ADDR_W+1: number of instructions loaded.
- `overflow`  out  1: sticky; a write was dropped because the RAM was full.
- `drop_err`  out  1: sticky; a write was dropped because it arrived while running.

## Operation
- **Control words:** a word with `npu_inst[127:4]==0` is a control word, not an instruction.
  - 1 = CLEAR.
  - 2 = START.
  - All other control values are ignored.
- **Instruction words:**
  - In IDLE with `inst_count<DEPTH`: written at `wr_ptr`, then `wr_ptr`/`inst_count` increment.
  - In IDLE when full: dropped, `overflow` set.
  - Outside IDLE: dropped, `drop_err` set.
- **CLEAR, any state:**
  - `wr_ptr`, `rd_ptr`, `inst_count`, `overflow` and `drop_err` go to 0.
  - FSM goes to IDLE next cycle.
  - No further `exec_inst_en` pulse. A pulse that is in flight completes; nothing is retracted.
- **START:**
  - Ignored outside IDLE.
  - Ignored when `inst_count==0`.
  - Otherwise `rd_ptr` is set to 0 and the FSM goes to FETCH.
- **FSM:**
  - IDLE: `npu_inst_ready=1`.
  - FETCH: drives RAM read address `rd_ptr`, then goes to ISSUE.
  - ISSUE: `exec_inst` is loaded from RAM data and `exec_inst_en=1` for this cycle; `rd_ptr++`; then goes to WAIT_ACK.
  - WAIT_ACK: waits for `exec_ready==0`, then goes to WAIT_DONE.
  - WAIT_DONE: waits for `exec_ready==1`. If `rd_ptr==inst_count` it goes to IDLE, otherwise to FETCH.
- **Program retention:** the program is kept after a run, so a second START replays it unchanged.
- **`exec_inst` hold:** `exec_inst` holds its last value between issues.

## Timing
- **Reset values:**
  - `npu_inst_ready=1`.
  - `exec_inst_en=0`, `exec_inst=0`.
  - `inst_count=0`, `overflow=0`, `drop_err=0`.
  - FSM in IDLE.
- **Start latency:** START strobe at cycle T:
  - `npu_inst_ready` falls at T+1 (FETCH).
  - `exec_inst_en` is high at T+2.
- **Inter-instruction gap:** `exec_ready` rises in WAIT_DONE at cycle U:
  - Next `exec_inst_en` at U+2.
  - On the last instruction, `npu_inst_ready` rises at U+1.
- **Write latency:** `inst_count` updates the cycle after the strobe.
- **RAM:** synchronous, 1-cycle registered read. Write and read never target the same address in the same cycle, because writes occur only in IDLE.
- **Executor contract:** the executor drops `exec_ready` at least one cycle after `exec_inst_en`. `exec_ready` is ignored during the issue cycle.

## Configuration
- **With `NPU_INST_QUEUE_TIMEOUT_EN` defined:** WAIT_ACK has a counter. If `exec_ready` stays high for `ACK_TIMEOUT` cycles, the instruction is treated as complete and the FSM follows the WAIT_DONE exit rule. This covers single-cycle instructions.
- **Without it:** WAIT_ACK waits indefinitely and the counter is not built.

## Structure
- **Package `npu_inst_pkg`:**
  - FSM state enum: IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE.
  - `CMD_CLEAR=1`, `CMD_START=2`.
  - `INST_W` default.
  - Control-word detect mask `[127:4]`.
- **Sub-module `npu_inst_ram`:** simple dual-port RAM with one write port and one registered read port, sized DEPTH×INST_W, inferable as block RAM.
- **Top `npu_inst_queue`:** holds pointers, counters, sticky flags and the FSM.

## Test plan
- **Reset and empty start:** reset, then START with the queue empty → `npu_inst_ready=1`, `exec_inst_en=0`, `inst_count=0`, and no pulse within 20 cycles.
- **Basic run:** load A, B, C, then START. Executor model drops `exec_ready` 1 cycle after each issue and holds it low 5 cycles →
  - exactly 3 pulses carrying A, B, C in order;
  - first pulse at T+2;
  - each later pulse 2 cycles after `exec_ready` rises;
  - `npu_inst_ready` high 1 cycle after the final rise.
- **Replay and drop:** START again without reloading → A, B, C replayed. A write issued mid-run sets `drop_err=1` and leaves `inst_count=3`.
- **Overflow and clear:**
  - Write 1025 instructions → `inst_count=1024`, `overflow=1`.
  - CLEAR → `inst_count=0`, `overflow=0`.
- **Abort:** CLEAR issued in WAIT_DONE after the 2nd issue → no 3rd pulse, `npu_inst_ready=1` next cycle.
- **Ack timeout:** executor holds `exec_ready` high permanently.
  - With the macro: issues spaced `ACK_TIMEOUT`+2 cycles apart, and the run completes.
  - Without the macro: the FSM stays in WAIT_ACK and `npu_inst_ready` stays 0.
